// File: rtl/icepic_prog_loader.sv
// Byte-stream loader for iCEPIC program RAM: packs little-endian byte pairs into
// INST_W-bit words (LOAD) or writes FILL_WORD over an address range (FILL).
module icepic_prog_loader #(
    parameter int                INST_W    = 12,
    parameter int                ADDR_W    = 9,
    parameter logic [INST_W-1:0] FILL_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [INST_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_range,
    output logic [7:0]        checksum
);

    localparam int         HB      = INST_W - 8;
    localparam logic [7:0] HI_USED = 8'((1 << HB) - 1);

    typedef enum logic [2:0] {IDLE, LO, HI, WR, FILL, FIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic [7:0]        word_lo;
    logic              accept;

    assign accept = in_valid && in_ready;

    // Outputs are registered alongside the state they belong to, so each one
    // is valid during the same cycle that the FSM sits in the matching state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            word_lo   <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_range <= 1'b0;
            checksum  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        checksum  <= '0;
                        err_range <= 1'b0;
                        busy      <= 1'b1;
                        addr      <= base_addr;
                        remaining <= word_count;
                        if (word_count == '0) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else if (!mode) begin
                            in_ready <= 1'b1;
                            state    <= LO;
                        end else begin
                            // First fill write lands in the very first FILL cycle.
                            mem_we    <= 1'b1;
                            mem_addr  <= base_addr;
                            mem_wdata <= FILL_WORD;
                            addr      <= base_addr + 1'b1;
                            remaining <= word_count - 1'b1;
                            state     <= FILL;
                        end
                    end
                end
                LO: begin
                    if (accept) begin
                        word_lo  <= in_data;
                        checksum <= checksum + in_data;
                        state    <= HI;
                    end
                end
                HI: begin
                    if (accept) begin
                        checksum <= checksum + in_data;
                        if ((in_data & ~HI_USED) != '0) begin
                            err_range <= 1'b1;
                        end
                        mem_we    <= 1'b1;
                        mem_addr  <= addr;
                        mem_wdata <= {in_data[HB-1:0], word_lo};
                        addr      <= addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        in_ready  <= 1'b0;
                        state     <= WR;
                    end
                end
                WR: begin
                    mem_we <= 1'b0;
                    if (remaining == '0) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= LO;
                    end
                end
                FILL: begin
                    if (remaining == '0) begin
                        mem_we <= 1'b0;
                        done   <= 1'b1;
                        state  <= FIN;
                    end else begin
                        mem_addr  <= addr;
                        addr      <= addr + 1'b1;
                        remaining <= remaining - 1'b1;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
